// File: rtl/sram_stream_reader.sv
// rtl/sram_stream_reader.sv - SRAM burst read sequencer with FWFT output FIFO (optional SRAM_STREAM_STRIDE_EN)
module sram_stream_reader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH:0]   i_count,
`ifdef SRAM_STREAM_STRIDE_EN
    input  logic [ADDR_WIDTH-1:0] i_stride,
`endif
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_sram_read_en,
    output logic [ADDR_WIDTH-1:0] o_sram_read_addr,
    input  logic [DATA_WIDTH-1:0] i_sram_data,
    input  logic                  i_sram_data_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = CW + 1;
    localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic [ADDR_WIDTH-1:0] r_cur_addr;
    logic [ADDR_WIDTH-1:0] r_stride;
    logic [ADDR_WIDTH:0]   r_issue_rem;
    logic                  r_rd_en;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_cap;
    logic                  r_done;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_fifo_cnt;

    logic [ADDR_WIDTH-1:0] w_step_in;
    logic                  w_start_go;
    logic                  w_issue;
    logic                  w_done_set;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_fifo_empty;
    logic                  w_drained;
    logic [SW-1:0]         w_credit_used;

`ifdef SRAM_STREAM_STRIDE_EN
    assign w_step_in = i_stride;
`else
    assign w_step_in = ADDR_WIDTH'(1);
`endif

    // r_rd_en: read on the SRAM bus this cycle; r_cap: its data is due now.
    // Both are words already owed a FIFO slot, so both count against credit.
    assign w_fifo_empty  = (r_fifo_cnt == '0);
    assign w_push        = r_cap && i_sram_data_valid;
    assign w_pop         = !w_fifo_empty && i_ready;
    assign w_credit_used = SW'(r_fifo_cnt) + SW'(r_rd_en) + SW'(r_cap);
    // Burst ends at the edge where the last word leaves, so done follows the final transfer directly.
    assign w_drained     = !r_rd_en && !r_cap &&
                           (w_fifo_empty || (r_fifo_cnt == CW'(1) && w_pop));

    assign o_busy           = (r_state != ST_IDLE);
    assign o_done           = r_done;
    assign o_sram_read_en   = r_rd_en;
    assign o_sram_read_addr = r_rd_addr;
    assign o_valid          = !w_fifo_empty;
    assign o_data           = w_fifo_empty ? '0 : r_mem[r_rd_ptr];

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and issue decision; the first read goes out straight from IDLE
    always_comb begin
        w_next_state = r_state;
        w_start_go   = 1'b0;
        w_issue      = 1'b0;
        w_done_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_count != '0) begin
                        w_start_go   = 1'b1;
                        w_next_state = (i_count == CNT_ONE) ? ST_DRAIN : ST_READ;
                    end else begin
                        w_done_set = 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (r_issue_rem != '0 && w_credit_used < SW'(FIFO_DEPTH)) begin
                    w_issue = 1'b1;
                    if (r_issue_rem == CNT_ONE) begin
                        w_next_state = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_drained) begin
                    w_done_set   = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Read address generation, registered SRAM strobes and done pulse
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_cur_addr  <= '0;
            r_stride    <= '0;
            r_issue_rem <= '0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_cap       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_rd_en <= w_start_go || w_issue;
            r_cap   <= r_rd_en;
            r_done  <= w_done_set;
            if (w_start_go) begin
                r_rd_addr   <= i_base_addr;
                r_cur_addr  <= i_base_addr + w_step_in;
                r_stride    <= w_step_in;
                r_issue_rem <= i_count - CNT_ONE;
            end else if (w_issue) begin
                r_rd_addr   <= r_cur_addr;
                r_cur_addr  <= r_cur_addr + r_stride;
                r_issue_rem <= r_issue_rem - CNT_ONE;
            end
        end
    end

    // Output FIFO: capture returning SRAM words, pop on stream handshake
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_sram_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + CW'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - CW'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

endmodule
